slurm16_memory_arbiter: RTL and testbench
=========================================

# slurm16_memory_arbiter

- Shares one synchronous 16-bit SRAM port between the SLURM16 CPU memory interface and up to three DMA masters (graphics, audio, flash loader).
- Port 0 is the CPU, which has priority. Ports 1..N-1 are served round-robin, with starvation protection that temporarily outranks the CPU.
- Drives the SRAM address, data, write and mask lines, and returns the grant handshake and read data to each requester.
- Sits between `cpu_memory_interface`'s external memory port and the SRAM / bus controller.

## Interface

Parameters:
- `N_PORTS`, default 4: number of requesters, 2..4; port 0 is the CPU.
- `ADDRESS_BITS`, default 16: word address width.
- `BITS`, default 16: data width.
- `STARVE_LIMIT`, default 8: consecutive denied cycles after which a DMA port outranks the CPU; valid range 1..15.

Ports:
- `CLK`  in  1  clock; all logic rising-edge.
- `RSTb`  in  1  reset, synchronous, active-low.
- `req_valid`  in  `N_PORTS`  per-port request.
- `req_wr`  in  `N_PORTS`  per-port write (1) / read (0).
- `req_address`  in  `N_PORTS*ADDRESS_BITS`  packed; port i at `[i*ADDRESS_BITS +: ADDRESS_BITS]`.
- `req_data`  in  `N_PORTS*BITS`  packed write data.
- `req_wr_mask`  in  `N_PORTS*2`  packed byte mask; bit1 = high byte, bit0 = low byte.
- `req_ready`  out  `N_PORTS`  one-hot grant, combinational, same cycle as request.
- `rd_data`  out  `BITS`  shared read data.
- `rd_valid`  out  `N_PORTS`  one-hot read-data strobe.
- `sram_address`  out  `ADDRESS_BITS`  registered.
- `sram_wdata`  out  `BITS`  registered.
- `sram_wr_mask`  out  2  registered.
- `sram_wr`  out  1  registered.
- `sram_valid`  out  1  registered access strobe.
- `sram_rdata`  in  `BITS`  SRAM read data, valid one cycle after `sram_valid`.

## Operation

- **Handshake:**
  - A requester holds valid/wr/address/data/mask stable until it sees `req_ready[i]` high.
  - The transfer is accepted on the rising edge where valid and ready are both high.
  - The requester may present a new request in the very next cycle.
- **Arbitration:** evaluated combinationally every cycle; at most one `req_ready` bit is high. Priority order:
  1. Starved DMA ports, i.e. `wait_cnt[i] >= STARVE_LIMIT`. Among several, pick the first at or after `rr_ptr`, cyclic over 1..N-1.
  2. Port 0, if valid.
  3. Remaining valid DMA ports, first at or after `rr_ptr`.
- **Round-robin pointer (`rr_ptr`):**
  - After granting DMA port k, `rr_ptr` becomes k+1, wrapping from N-1 to 1.
  - A CPU grant leaves `rr_ptr` unchanged.
- **Wait counters (one per DMA port, 4-bit, saturating at 15):**
  - Increment when valid and not granted.
  - Clear when granted or when valid is low.
- **Issue stage:**
  - On an accepted transfer, register `sram_address`, `sram_wdata`, `sram_wr_mask`, `sram_wr`; set `sram_valid` = 1.
  - Record the winner id and a read flag.
  - With no grant, `sram_valid` = 0 and `sram_wr` = 0. The other SRAM outputs hold their last values.
- **Read return:**
  - The stage-2 register carries the id of a read issued the previous cycle.
  - `rd_valid[id]` = 1 while `rd_data` = `sram_rdata` (combinational pass-through).
  - Writes produce no `rd_valid`.
- **Read mask:** ignored by the arbiter for reads; it is forwarded to `sram_wr_mask` for byte-lane steering.

## Timing

- **Reset values:**
  - Registered outputs: `sram_valid` = 0, `sram_wr` = 0, `sram_address` = 0, `sram_wdata` = 0, `sram_wr_mask` = 0.
  - Combinational outputs: `rd_valid` = 0 and `req_ready` = 0 throughout reset.
  - Internal state: `rr_ptr` = 1, all wait counters = 0, pipeline id/flags cleared.
- **Read latency:** request accepted at edge E → `sram_valid` high in cycle E+1 → `rd_valid` and `rd_data` in cycle E+2.
- **Write latency:** the write reaches SRAM in cycle E+1.
- **Throughput:** one access per cycle, including back-to-back accesses from the same port or alternating ports.
- **Reset mid-operation:**
  - Reset asserted while reads are in flight clears the pipeline; no `rd_valid` is issued for those reads.
  - While reset is asserted, no grants are issued regardless of `req_valid`.
- **Simultaneous events:**
  - A starved port and the CPU requesting together: the starved port wins.
  - A port whose counter reaches `STARVE_LIMIT` at an edge is eligible as starved from the next cycle.
- **N_PORTS = 2:** port 1 is the only DMA port; `rr_ptr` stays 1.

## Test plan

- **Single read:** CPU read of address 0x1234 with the SRAM model returning 0xBEEF → `req_ready[0]` in cycle 0, `sram_address` = 0x1234 in cycle 1, `rd_valid` = 0001 with `rd_data` = 0xBEEF in cycle 2.
- **Round-robin fairness:** ports 1, 2 and 3 request continuously with the CPU idle → grant sequence 1, 2, 3, 1, 2, 3; `sram_valid` held high every cycle.
- **Starvation:** CPU requests every cycle and port 2 requests continuously, `STARVE_LIMIT` = 8 → port 2 denied for 8 cycles and granted in the 9th; the CPU is granted in all other cycles.
- **Byte write:** port 1 writes 0xAB00 to address 0x0040 with mask 10 → cycle 1 shows `sram_wr` = 1, `sram_wr_mask` = 10, `sram_wdata` = 0xAB00; no `rd_valid` follows.
- **Interleaved reads:** back-to-back reads from ports 0 and 3 with SRAM data 0x1111 then 0x2222 → `rd_valid` = 0001 with 0x1111, then `rd_valid` = 1000 with 0x2222, in consecutive cycles.
- **Reset during a read:** `RSTb` low for one cycle immediately after a read grant → no `rd_valid`; all outputs at reset values; `rr_ptr` = 1; the next grant follows normal priority.

Source files
------------

// File: rtl/slurm16_memory_arbiter.sv
// -----------------------------------------------------------------------------
// slurm16_memory_arbiter
//
// Shares one synchronous SRAM port between the SLURM16 CPU (port 0) and up to
// three DMA masters (ports 1..N_PORTS-1). The CPU normally wins. DMA ports are
// served round-robin. A DMA port that has been refused STARVE_LIMIT cycles in
// a row outranks the CPU until it is served.
//
// Pipeline:
//   cycle E   : request/ready handshake (grant is combinational)
//   cycle E+1 : SRAM access driven from registers (sram_valid = 1)
//   cycle E+2 : read data returned on rd_data, rd_valid[id] strobed
//
// Ports:
//   CLK, RSTb        clock, synchronous active-low reset
//   req_valid/wr     per-port request and write flag
//   req_address      packed word addresses, port i at [i*ADDRESS_BITS +: ADDRESS_BITS]
//   req_data         packed write data,     port i at [i*BITS +: BITS]
//   req_wr_mask      packed byte masks,     port i at [i*2 +: 2] (bit1 = high byte)
//   req_ready        one-hot grant, same cycle as the request
//   rd_data/rd_valid shared read data and one-hot read strobe
//   sram_*           registered SRAM command outputs, sram_rdata read return
// -----------------------------------------------------------------------------
module slurm16_memory_arbiter #(
    parameter int N_PORTS      = 4,
    parameter int ADDRESS_BITS = 16,
    parameter int BITS         = 16,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                           CLK,
    input  logic                           RSTb,
    input  logic [N_PORTS-1:0]             req_valid,
    input  logic [N_PORTS-1:0]             req_wr,
    input  logic [N_PORTS*ADDRESS_BITS-1:0] req_address,
    input  logic [N_PORTS*BITS-1:0]        req_data,
    input  logic [N_PORTS*2-1:0]           req_wr_mask,
    output logic [N_PORTS-1:0]             req_ready,
    output logic [BITS-1:0]                rd_data,
    output logic [N_PORTS-1:0]             rd_valid,
    output logic [ADDRESS_BITS-1:0]        sram_address,
    output logic [BITS-1:0]                sram_wdata,
    output logic [1:0]                     sram_wr_mask,
    output logic                           sram_wr,
    output logic                           sram_valid,
    input  logic [BITS-1:0]                sram_rdata
);

    localparam logic [3:0] STARVE_TH = 4'(STARVE_LIMIT);
    localparam logic [2:0] LAST_DMA  = 3'(N_PORTS - 1);

    logic [3:0] wait_cnt [N_PORTS];
    logic [2:0] rr_ptr;

    logic       grant_valid;
    logic [1:0] grant_id;

    // s1: access currently on the SRAM port; s2: read whose data is returning
    logic       s1_rd;
    logic [1:0] s1_id;
    logic       s2_rd;
    logic [1:0] s2_id;

    // DMA port visited at position 'off' of a cyclic scan over 1..N_PORTS-1
    // that starts at 'base'.
    function automatic logic [1:0] rr_port(input logic [2:0] base, input int off);
        logic [2:0] p;
        p = base + 3'(off);
        if (p > LAST_DMA) begin
            p = p - LAST_DMA;
        end
        return p[1:0];
    endfunction

    always_comb begin
        grant_valid = 1'b0;
        grant_id    = 2'd0;
        if (RSTb) begin
            // starved DMA ports first
            for (int off = 0; off < N_PORTS - 1; off++) begin
                if (!grant_valid && req_valid[rr_port(rr_ptr, off)] &&
                    (wait_cnt[rr_port(rr_ptr, off)] >= STARVE_TH)) begin
                    grant_valid = 1'b1;
                    grant_id    = rr_port(rr_ptr, off);
                end
            end
            if (!grant_valid && req_valid[0]) begin
                grant_valid = 1'b1;
                grant_id    = 2'd0;
            end
            for (int off = 0; off < N_PORTS - 1; off++) begin
                if (!grant_valid && req_valid[rr_port(rr_ptr, off)]) begin
                    grant_valid = 1'b1;
                    grant_id    = rr_port(rr_ptr, off);
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (grant_valid) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTb) begin
            rr_ptr       <= 3'd1;
            for (int i = 0; i < N_PORTS; i++) begin
                wait_cnt[i] <= '0;
            end
            sram_address <= '0;
            sram_wdata   <= '0;
            sram_wr_mask <= '0;
            sram_wr      <= 1'b0;
            sram_valid   <= 1'b0;
            s1_rd        <= 1'b0;
            s1_id        <= '0;
            s2_rd        <= 1'b0;
            s2_id        <= '0;
        end else begin
            sram_valid <= grant_valid;
            sram_wr    <= grant_valid & req_wr[grant_id];
            if (grant_valid) begin
                sram_address <= req_address[int'(grant_id)*ADDRESS_BITS +: ADDRESS_BITS];
                sram_wdata   <= req_data[int'(grant_id)*BITS +: BITS];
                sram_wr_mask <= req_wr_mask[int'(grant_id)*2 +: 2];
            end

            s1_rd <= grant_valid & ~req_wr[grant_id];
            s1_id <= grant_id;
            s2_rd <= s1_rd;
            s2_id <= s1_id;

            // CPU grants leave the pointer alone so DMA order is unaffected
            if (grant_valid && (grant_id != 2'd0)) begin
                rr_ptr <= ({1'b0, grant_id} == LAST_DMA) ? 3'd1 : {1'b0, grant_id} + 3'd1;
            end

            wait_cnt[0] <= '0;
            for (int i = 1; i < N_PORTS; i++) begin
                if (!req_valid[i] || (grant_valid && (grant_id == 2'(i)))) begin
                    wait_cnt[i] <= '0;
                end else if (wait_cnt[i] != 4'hF) begin
                    wait_cnt[i] <= wait_cnt[i] + 4'd1;
                end
            end
        end
    end

    always_comb begin
        rd_valid = '0;
        if (RSTb && s2_rd) begin
            rd_valid[s2_id] = 1'b1;
        end
    end

    assign rd_data = sram_rdata;

endmodule

// File: tb/tb_slurm16_memory_arbiter.sv
module tb_slurm16_memory_arbiter;

    localparam int N     = 4;
    localparam int LIMIT = 8;

    logic          CLK = 1'b0;
    logic          RSTb = 1'b0;
    logic [N-1:0]  req_valid = '0;
    logic [N-1:0]  req_wr = '0;
    logic [N*16-1:0] req_address = '0;
    logic [N*16-1:0] req_data = '0;
    logic [N*2-1:0]  req_wr_mask = '0;
    logic [N-1:0]  req_ready;
    logic [15:0]   rd_data;
    logic [N-1:0]  rd_valid;
    logic [15:0]   sram_address;
    logic [15:0]   sram_wdata;
    logic [1:0]    sram_wr_mask;
    logic          sram_wr;
    logic          sram_valid;
    logic [15:0]   sram_rdata = '0;

    slurm16_memory_arbiter #(
        .N_PORTS(N), .ADDRESS_BITS(16), .BITS(16), .STARVE_LIMIT(LIMIT)
    ) dut (
        .CLK(CLK), .RSTb(RSTb),
        .req_valid(req_valid), .req_wr(req_wr), .req_address(req_address),
        .req_data(req_data), .req_wr_mask(req_wr_mask), .req_ready(req_ready),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .sram_address(sram_address), .sram_wdata(sram_wdata),
        .sram_wr_mask(sram_wr_mask), .sram_wr(sram_wr), .sram_valid(sram_valid),
        .sram_rdata(sram_rdata)
    );

    always #5 CLK = ~CLK;

    // SRAM model: 16 words, indexed by the low address bits
    logic [15:0] mem [16];
    always @(posedge CLK) begin
        if (sram_valid) begin
            if (sram_wr) begin
                if (sram_wr_mask[1]) mem[sram_address[3:0]][15:8] <= sram_wdata[15:8];
                if (sram_wr_mask[0]) mem[sram_address[3:0]][7:0]  <= sram_wdata[7:0];
            end else begin
                sram_rdata <= mem[sram_address[3:0]];
            end
        end
    end

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
        logic [1:0]  mask;
        logic        wr;
    } sram_exp_t;

    typedef struct packed {
        logic [3:0]  onehot;
        logic [15:0] data;
    } rd_exp_t;

    sram_exp_t exp_sram_q[$];
    rd_exp_t   exp_rd_q[$];
    int        glog[$];

    int total = 0;
    int bad   = 0;

    // pending requests held by each requester until granted
    bit          pv    [N];
    bit          pwr   [N];
    logic [15:0] paddr [N];
    logic [15:0] pdata [N];
    logic [1:0]  pmask [N];

    // reference model state
    bit [15:0] ref_mem [16];
    int        m_rr;
    int        m_wcnt [N];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int p, input bit wr, input logic [15:0] a,
                           input logic [15:0] d, input logic [1:0] m);
        pv[p] = 1'b1; pwr[p] = wr; paddr[p] = a; pdata[p] = d; pmask[p] = m;
    endtask

    task automatic apply_inputs();
        for (int i = 0; i < N; i++) begin
            req_valid[i]            = pv[i];
            req_wr[i]               = pwr[i];
            req_address[i*16 +: 16] = paddr[i];
            req_data[i*16 +: 16]    = pdata[i];
            req_wr_mask[i*2 +: 2]   = pmask[i];
        end
    endtask

    function automatic bit any_pending();
        for (int i = 0; i < N; i++) if (pv[i]) return 1'b1;
        return 1'b0;
    endfunction

    // DMA ports in the order they are considered: starting at m_rr, cyclic over 1..N-1
    function automatic int model_pick();
        int order[$];
        for (int i = 0; i < N - 1; i++) order.push_back(((m_rr - 1 + i) % (N - 1)) + 1);
        foreach (order[i]) if (pv[order[i]] && m_wcnt[order[i]] >= LIMIT) return order[i];
        if (pv[0]) return 0;
        foreach (order[i]) if (pv[order[i]]) return order[i];
        return -1;
    endfunction

    task automatic eval_cycle();
        int w;
        int dw;
        logic [3:0] er;
        sram_exp_t se;
        rd_exp_t re;
        apply_inputs();
        #1;
        w  = model_pick();
        er = (w >= 0) ? 4'(1 << w) : 4'd0;
        chk("req_ready", req_ready, er);
        dw = -1;
        for (int i = 0; i < N; i++) if (req_ready[i]) dw = i;
        glog.push_back(dw);
        if (w >= 0) begin
            se.addr = paddr[w]; se.data = pdata[w]; se.mask = pmask[w]; se.wr = pwr[w];
            exp_sram_q.push_back(se);
            if (pwr[w]) begin
                if (pmask[w][1]) ref_mem[paddr[w][3:0]][15:8] = pdata[w][15:8];
                if (pmask[w][0]) ref_mem[paddr[w][3:0]][7:0]  = pdata[w][7:0];
            end else begin
                re.onehot = er;
                re.data   = ref_mem[paddr[w][3:0]];
                exp_rd_q.push_back(re);
            end
        end
        for (int k = 1; k < N; k++) begin
            if (pv[k] && k != w) m_wcnt[k] = (m_wcnt[k] >= 15) ? 15 : m_wcnt[k] + 1;
            else                 m_wcnt[k] = 0;
        end
        if (w > 0) m_rr = (w == N - 1) ? 1 : w + 1;
        if (w >= 0) pv[w] = 1'b0;
    endtask

    task automatic drive_cycle();
        @(posedge CLK);
        #1;
        eval_cycle();
    endtask

    task automatic drain();
        int budget = 0;
        while (any_pending() && budget < 200) begin
            drive_cycle();
            budget++;
        end
        if (any_pending()) chk("drain_timeout", 1, 0);
        for (int i = 0; i < 3; i++) drive_cycle();
    endtask

    task automatic model_reset();
        m_rr = 1;
        for (int i = 0; i < N; i++) m_wcnt[i] = 0;
    endtask

    // monitor: pops expectations whenever the DUT presents an access or read data
    initial begin
        sram_exp_t se;
        rd_exp_t re;
        forever begin
            @(negedge CLK);
            if (sram_valid) begin
                if (exp_sram_q.size() == 0) begin
                    chk("sram_unexpected", 1, 0);
                end else begin
                    se = exp_sram_q.pop_front();
                    chk("sram_address", sram_address, se.addr);
                    chk("sram_wr", sram_wr, se.wr);
                    chk("sram_wdata", sram_wdata, se.data);
                    chk("sram_wr_mask", sram_wr_mask, se.mask);
                end
            end else begin
                chk("sram_wr_idle", sram_wr, 0);
            end
            if (rd_valid !== '0) begin
                if (exp_rd_q.size() == 0) begin
                    chk("rd_unexpected", rd_valid, 0);
                end else begin
                    re = exp_rd_q.pop_front();
                    chk("rd_valid", rd_valid, re.onehot);
                    chk("rd_data", rd_data, re.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int first2;
        int rr_exp [6] = '{1, 2, 3, 1, 2, 3};
        model_reset();
        for (int i = 0; i < N; i++) begin
            pv[i] = 0; pwr[i] = 0; paddr[i] = '0; pdata[i] = '0; pmask[i] = '0;
        end

        // reset with every port requesting: no grants, no read strobes
        for (int i = 0; i < N; i++) set_req(i, 0, 16'(i), 16'h0, 2'b11);
        apply_inputs();
        for (int c = 0; c < 3; c++) begin
            @(posedge CLK); #2;
            chk("reset_ready", req_ready, 0);
            chk("reset_rd_valid", rd_valid, 0);
        end
        chk("reset_sram_valid", sram_valid, 0);
        chk("reset_sram_wr", sram_wr, 0);
        chk("reset_sram_address", sram_address, 0);
        chk("reset_sram_wdata", sram_wdata, 0);
        chk("reset_sram_wr_mask", sram_wr_mask, 0);
        for (int i = 0; i < N; i++) pv[i] = 0;
        RSTb = 1'b1;
        apply_inputs();

        // round robin among DMA ports with the CPU idle
        glog.delete();
        for (int c = 0; c < 6; c++) begin
            for (int p = 1; p < N; p++)
                if (!pv[p]) set_req(p, 1, 16'($urandom), 16'($urandom), 2'b11);
            drive_cycle();
        end
        for (int i = 0; i < 6; i++) chk("rr_seq", glog[i], rr_exp[i]);
        for (int i = 0; i < N; i++) pv[i] = 0;
        drive_cycle();
        drain();

        // starvation: CPU every cycle, port 2 continuously until served
        glog.delete();
        for (int c = 0; c < 10; c++) begin
            if (!pv[0]) set_req(0, 1, 16'($urandom), 16'($urandom), 2'b11);
            if (c == 0) set_req(2, 1, 16'($urandom), 16'($urandom), 2'b11);
            drive_cycle();
        end
        first2 = -1;
        for (int i = glog.size() - 1; i >= 0; i--) if (glog[i] == 2) first2 = i;
        chk("starve_grant_cycle", first2, LIMIT);
        for (int i = 0; i < 10; i++) if (i != LIMIT) chk("starve_cpu_grant", glog[i], 0);
        pv[0] = 0;
        drain();

        // fill memory through the arbiter so every later read has known data
        for (int a = 0; a < 16; a++) begin
            set_req(1, 1, 16'(a), 16'($urandom), 2'b11);
            drive_cycle();
        end
        drain();

        // single CPU read returning 0xBEEF from 0x1234
        set_req(1, 1, 16'h1234, 16'hBEEF, 2'b11);
        drive_cycle();
        set_req(0, 0, 16'h1234, 16'h0, 2'b00);
        drive_cycle();
        chk("single_read_grant", glog[glog.size() - 1], 0);
        drain();

        // byte write of the high lane
        set_req(1, 1, 16'h0040, 16'hAB00, 2'b10);
        drive_cycle();
        drain();

        // interleaved reads from ports 0 and 3
        set_req(1, 1, 16'h0100, 16'h1111, 2'b11);
        drive_cycle();
        set_req(2, 1, 16'h0203, 16'h2222, 2'b11);
        drive_cycle();
        set_req(0, 0, 16'h0100, 16'h0, 2'b11);
        set_req(3, 0, 16'h0203, 16'h0, 2'b11);
        drive_cycle();
        drive_cycle();
        drain();

        // reset for one cycle right after a CPU read grant
        set_req(1, 0, 16'h0005, 16'h0, 2'b11);
        drive_cycle();
        drain();
        set_req(0, 0, 16'h0006, 16'h0, 2'b11);
        drive_cycle();
        @(posedge CLK); #1;
        RSTb = 1'b0;
        set_req(1, 0, 16'h0007, 16'h0, 2'b11);
        set_req(2, 0, 16'h0008, 16'h0, 2'b11);
        apply_inputs();
        #1;
        chk("midreset_ready", req_ready, 0);
        chk("midreset_rd_valid", rd_valid, 0);
        @(posedge CLK); #1;
        exp_rd_q.delete();
        model_reset();
        chk("midreset_sram_valid", sram_valid, 0);
        chk("midreset_sram_wr", sram_wr, 0);
        chk("midreset_sram_address", sram_address, 0);
        chk("midreset_sram_wdata", sram_wdata, 0);
        chk("midreset_sram_wr_mask", sram_wr_mask, 0);
        chk("midreset_rd_valid_after", rd_valid, 0);
        RSTb = 1'b1;
        eval_cycle();
        chk("post_reset_grant", glog[glog.size() - 1], 1);
        drain();

        // random traffic
        for (int c = 0; c < 300; c++) begin
            for (int p = 0; p < N; p++) begin
                if (!pv[p] && ($urandom_range(0, 3) < ((p == 0) ? 3 : 2)))
                    set_req(p, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                            2'($urandom_range(0, 3)));
            end
            drive_cycle();
        end
        drain();

        chk("exp_sram_left", exp_sram_q.size(), 0);
        chk("exp_rd_left", exp_rd_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
